// File: rtl/seg_pkg.sv
// Shared constants and types for the seven-segment scan driver.
package seg_pkg;

  localparam int NUM_DIGITS = 6;

  // Active-low segment patterns: {dp, g, f, e, d, c, b, a}.
  localparam logic [7:0] SEG_OFF  = 8'hFF;
  localparam logic [7:0] SEG_DASH = 8'hBF;

  // Slots whose decimal point is lit (seconds ones, minutes ones).
  localparam logic [NUM_DIGITS-1:0] DP_SLOT_MASK = 6'b010100;

  // Digit slot order, rightmost digit first.
  typedef enum logic [2:0] {
    MS_ONES  = 3'd0,
    MS_TENS  = 3'd1,
    SEC_ONES = 3'd2,
    SEC_TENS = 3'd3,
    MIN_ONES = 3'd4,
    MIN_TENS = 3'd5
  } slot_e;

  // Next slot in scan order, wrapping from the leftmost back to the rightmost digit.
  function automatic logic [2:0] next_slot(input logic [2:0] d);
    return (d == 3'(MIN_TENS)) ? 3'(MS_ONES) : d + 3'd1;
  endfunction

endpackage

// File: rtl/seg_scan_driver_if.sv
// Display-side bundle: BCD time values in, multiplexed segment/anode drive out.
interface seg_scan_driver_if;
  import seg_pkg::*;

  logic [7:0]            min_i;
  logic [7:0]            sec_i;
  logic [7:0]            ms_10_i;
  logic [NUM_DIGITS-1:0] an_o;
  logic [7:0]            seg_o;

  // Producer of the time values; observes the display drive.
  modport master (
    output min_i, sec_i, ms_10_i,
    input  an_o, seg_o
  );

  // The scan driver itself.
  modport slave (
    input  min_i, sec_i, ms_10_i,
    output an_o, seg_o
  );

endinterface

// File: rtl/bcd_to_seg.sv
// Combinational BCD digit to active-low seven-segment glyph (g..a).
// Non-decimal nibbles show a dash so a bad count is visible, not hidden.
module bcd_to_seg
  import seg_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  // Glyph lookup; anything above 9 falls through to the dash.
  always_comb begin
    seg = SEG_DASH[6:0];
    case (bcd)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = SEG_DASH[6:0];
    endcase
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Six-digit time-multiplexed common-anode display driver.
// A snapshot of min/sec/10ms is taken once per frame so each frame is coherent;
// anodes are blanked for the first BLANK_CYC cycles of each slot to avoid ghosting.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 500,
  parameter int BLANK_LZ  = 1
) (
  input  logic             clk_core,
  input  logic             rst,
  seg_scan_driver_if.slave bus
);

  localparam int             PW     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0]  P_LAST = PW'(SCAN_DIV - 1);

  logic [PW-1:0]           p_reg, p_next;
  logic [2:0]              d_reg, d_next;
  logic [23:0]             snap_reg, snap_next;
  logic [NUM_DIGITS-1:0]   an_reg, an_next;
  logic [7:0]              seg_reg, seg_next;

  logic                    slot_end;
  logic                    frame_end;
  logic                    blank;
  logic                    dp_on;
  logic [NUM_DIGITS-1:0]   slot_hit;
  logic [3:0]              cur_nib;
  logic [6:0]              glyph;

  assign slot_end  = (p_reg == P_LAST);
  assign frame_end = slot_end && (d_reg == 3'(MIN_TENS));

  // One-hot of the slot currently being scanned.
  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_slot_hit
    assign slot_hit[gi] = (d_reg == 3'(gi));
  end

  // With no blank window the comparison would be constant, so leave it out entirely.
  if (BLANK_CYC == 0) begin : g_no_blank
    assign blank = 1'b0;
  end else begin : g_blank
    assign blank = (p_reg < PW'(BLANK_CYC));
  end

  assign dp_on = |(slot_hit & DP_SLOT_MASK);

  // Prescaler, digit index and frame snapshot advance.
  always_comb begin
    p_next    = slot_end ? '0 : p_reg + PW'(1);
    d_next    = slot_end ? next_slot(d_reg) : d_reg;
    snap_next = frame_end ? {bus.min_i, bus.sec_i, bus.ms_10_i} : snap_reg;
  end

  // Select the snapshot nibble for the current slot; snapshot nibble i maps to slot i.
  always_comb begin
    cur_nib = snap_reg[3:0];
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (d_reg == 3'(i)) cur_nib = snap_reg[i*4 +: 4];
    end
  end

  bcd_to_seg u_dec (
    .bcd (cur_nib),
    .seg (glyph)
  );

  // Output pattern for the current slot: glyph plus dp, leading-zero blank, anode select.
  always_comb begin
    seg_next = {~dp_on, glyph};
    if ((BLANK_LZ != 0) && (d_reg == 3'(MIN_TENS)) && (cur_nib == 4'd0)) begin
      seg_next = SEG_OFF;
    end
    an_next = blank ? '1 : ~slot_hit;
  end

  // Scan state: prescaler, digit index and coherent value snapshot.
  always_ff @(posedge clk_core or negedge rst) begin
    if (!rst) begin
      p_reg    <= '0;
      d_reg    <= 3'(MS_ONES);
      snap_reg <= '0;
    end else begin
      p_reg    <= p_next;
      d_reg    <= d_next;
      snap_reg <= snap_next;
    end
  end

  // Registered display drive, one cycle behind the scan state.
  always_ff @(posedge clk_core or negedge rst) begin
    if (!rst) begin
      an_reg  <= '1;
      seg_reg <= SEG_OFF;
    end else begin
      an_reg  <= an_next;
      seg_reg <= seg_next;
    end
  end

  assign bus.an_o  = an_reg;
  assign bus.seg_o = seg_reg;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver with a frame-arithmetic reference model.
// Two instances run side by side, one with leading-zero blanking and one without.
module tb_seg_scan_driver;

  localparam int SD    = 4;
  localparam int BC    = 1;
  localparam int FRAME = 6 * SD;

  // Glyphs for 0..9 as {g..a}, active low.
  localparam logic [6:0] GLYPH [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  logic       clk_core = 1'b0;
  logic       rst      = 1'b0;
  logic [7:0] min_v    = 8'h00;
  logic [7:0] sec_v    = 8'h00;
  logic [7:0] ms_v     = 8'h00;

  always #5 clk_core = ~clk_core;

  seg_scan_driver_if bus_lz ();
  seg_scan_driver_if bus_nlz ();

  assign bus_lz.min_i    = min_v;
  assign bus_lz.sec_i    = sec_v;
  assign bus_lz.ms_10_i  = ms_v;
  assign bus_nlz.min_i   = min_v;
  assign bus_nlz.sec_i   = sec_v;
  assign bus_nlz.ms_10_i = ms_v;

  seg_scan_driver #(.SCAN_DIV(SD), .BLANK_CYC(BC), .BLANK_LZ(1)) dut (
    .clk_core (clk_core),
    .rst      (rst),
    .bus      (bus_lz)
  );

  seg_scan_driver #(.SCAN_DIV(SD), .BLANK_CYC(BC), .BLANK_LZ(0)) dut_nlz (
    .clk_core (clk_core),
    .rst      (rst),
    .bus      (bus_nlz)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int jn    = 0;

  // Anode pattern for the k-th cycle since reset release.
  function automatic logic [5:0] model_an(input int k);
    int p;
    int d;
    logic [5:0] a;
    p = k % SD;
    d = (k / SD) % 6;
    a = 6'h3F;
    if (p >= BC) a[d] = 1'b0;
    return a;
  endfunction

  // Segment pattern for the k-th cycle given the frame's captured values.
  function automatic logic [7:0] model_seg(input int k, input logic [7:0] mn,
                                           input logic [7:0] sc, input logic [7:0] ms,
                                           input bit lz);
    int d;
    logic [3:0] nib;
    logic dp;
    logic [6:0] g;
    d = (k / SD) % 6;
    case (d)
      0:       nib = ms[3:0];
      1:       nib = ms[7:4];
      2:       nib = sc[3:0];
      3:       nib = sc[7:4];
      4:       nib = mn[3:0];
      default: nib = mn[7:4];
    endcase
    dp = !(d == 2 || d == 4);
    if (d == 5 && lz && nib == 4'd0) return 8'hFF;
    if (nib > 4'd9) g = 7'b0111111;
    else            g = GLYPH[int'(nib)];
    return {dp, g};
  endfunction

  int         mk         = 0;
  logic [7:0] sm_min     = 8'h00;
  logic [7:0] sm_sec     = 8'h00;
  logic [7:0] sm_ms      = 8'h00;
  logic [5:0] exp_an     = 6'h3F;
  logic [7:0] exp_seg_lz = 8'hFF;
  logic [7:0] exp_seg_nz = 8'hFF;

  // Reference model: cycle index since release, frame values captured at each frame's last cycle.
  always @(posedge clk_core or negedge rst) begin
    if (!rst) begin
      mk         <= 0;
      sm_min     <= 8'h00;
      sm_sec     <= 8'h00;
      sm_ms      <= 8'h00;
      exp_an     <= 6'h3F;
      exp_seg_lz <= 8'hFF;
      exp_seg_nz <= 8'hFF;
    end else begin
      exp_an     <= model_an(mk);
      exp_seg_lz <= model_seg(mk, sm_min, sm_sec, sm_ms, 1'b1);
      exp_seg_nz <= model_seg(mk, sm_min, sm_sec, sm_ms, 1'b0);
      if (mk % FRAME == FRAME - 1) begin
        sm_min <= min_v;
        sm_sec <= sec_v;
        sm_ms  <= ms_v;
      end
      mk <= mk + 1;
    end
  end

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h, want %h", nm, $time, act, req);
    end
  endtask

  // Continuous comparison of both instances against the model.
  always @(negedge clk_core) begin
    check("model_an_lz",  {2'b00, bus_lz.an_o},  {2'b00, exp_an});
    check("model_an_nlz", {2'b00, bus_nlz.an_o}, {2'b00, exp_an});
    check("model_seg_lz",  bus_lz.seg_o,  exp_seg_lz);
    check("model_seg_nlz", bus_nlz.seg_o, exp_seg_nz);
  end

  task automatic tick();
    @(negedge clk_core);
    jn++;
  endtask

  task automatic tick_to(input int n);
    while (jn < n) tick();
  endtask

  // Hand-computed expectation on the blanking instance (and optionally the other).
  task automatic lit(input string nm, input logic [5:0] an_req, input logic [7:0] seg_req);
    $display("check %-14s j=%0d an=%b seg=%h", nm, jn, bus_lz.an_o, bus_lz.seg_o);
    check({nm, "_an"},  {2'b00, bus_lz.an_o}, {2'b00, an_req});
    check({nm, "_seg"}, bus_lz.seg_o, seg_req);
  endtask

  initial begin
    // Reset held with inputs toggling: outputs stay dark.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_core);
      min_v = 8'(i * 17);
      sec_v = 8'(i * 3 + 1);
      ms_v  = 8'(~i);
      lit("in_reset", 6'h3F, 8'hFF);
    end

    // Release; first frame must show the all-zero reset snapshot.
    @(negedge clk_core);
    min_v = 8'h12;
    sec_v = 8'h34;
    ms_v  = 8'h56;
    rst   = 1'b1;
    jn    = 0;
    tick();       lit("f0_d0_blank", 6'h3F, 8'hC0);
    tick();       lit("f0_d0", 6'h3E, 8'hC0);
    tick_to(22);  lit("f0_d5_lz", 6'h1F, 8'hFF);
    check("f0_d5_nlz_seg", bus_nlz.seg_o, 8'hC0);

    // Second frame: 12:34.56 captured at the boundary.
    tick_to(26);  lit("f1_d0", 6'h3E, 8'h82);
    tick_to(30);  lit("f1_d1", 6'h3D, 8'h92);
    tick_to(33);  lit("f1_d2_blank", 6'h3F, 8'h19);
    sec_v = 8'h35;
    tick_to(34);  lit("f1_d2_coh", 6'h3B, 8'h19);
    tick_to(38);  lit("f1_d3", 6'h37, 8'hB0);
    tick_to(42);  lit("f1_d4", 6'h2F, 8'h24);
    tick_to(46);  lit("f1_d5", 6'h1F, 8'hF9);

    // Third frame picks up the changed seconds.
    tick_to(58);  lit("f2_d2_new", 6'h3B, 8'h12);
    tick_to(60);
    min_v = 8'h05;
    ms_v  = 8'hA3;

    // Fourth frame: invalid BCD tens and leading-zero minutes.
    tick_to(73);  lit("f3_d0_blank", 6'h3F, 8'hB0);
    tick_to(74);  lit("f3_d0", 6'h3E, 8'hB0);
    tick_to(78);  lit("f3_d1_dash", 6'h3D, 8'hBF);
    tick_to(90);  lit("f3_d4", 6'h2F, 8'h12);
    tick_to(94);  lit("f3_d5_lz", 6'h1F, 8'hFF);
    check("f3_d5_nlz_seg", bus_nlz.seg_o, 8'hC0);

    // Mid-frame reset at d3, p2: outputs drop to reset values before any clock edge.
    tick_to(110);
    #2 rst = 1'b0;
    #1 lit("midrst", 6'h3F, 8'hFF);
    check("midrst_nlz_an", {2'b00, bus_nlz.an_o}, 8'h3F);
    check("midrst_nlz_seg", bus_nlz.seg_o, 8'hFF);
    @(negedge clk_core);
    @(negedge clk_core);
    rst = 1'b1;
    jn  = 0;
    tick();       lit("rr_d0_blank", 6'h3F, 8'hC0);
    tick();       lit("rr_d0", 6'h3E, 8'hC0);
    tick_to(30);  lit("rr_f1_d1_dash", 6'h3D, 8'hBF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
